k_fifo_ctrl: RTL and testbench

Pointer and handshake controller for a small dual-port register-file FIFO (default 2 entries). Converts a valid/ready push interface and a valid/ready pop interface into the write-enable, write-address and read-address controls of an external combinational-read, clocked-write storage array. It maintains occupancy, full, empty and almost-full status. It sits between a producer and a consumer in the FIFO datapath and owns every sequencing decision for the array.

---
 rtl/k_fifo_pkg.sv | 20 ++
 rtl/k_fifo_ptr.sv | 24 ++
 rtl/k_fifo_ctrl.sv | 114 +++++++++++
 tb/tb_k_fifo_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/k_fifo_pkg.sv
// k_fifo shared helpers: pointer width, depth and
// almost-full level legality for the FIFO controller.
package k_fifo_pkg;

  function automatic int k_fifo_ptr_w(input int addr_size);
    return addr_size + 1;
  endfunction

  function automatic int k_fifo_depth(input int addr_size);
    return 1 << addr_size;
  endfunction

  function automatic bit k_fifo_afull_ok(
    input int lvl,
    input int addr_size
  );
    return (lvl >= 1) && (lvl <= k_fifo_depth(addr_size));
  endfunction

endpackage

// File: rtl/k_fifo_ptr.sv
// Wrap-bit pointer register: MSB toggles once per DEPTH
// increments; clr gives a synchronous return to zero.
module k_fifo_ptr #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] ptr
);

  // clear wins over increment so a flushed op never lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/k_fifo_ctrl.sv
// Pointer/handshake controller for an external 2-port regfile FIFO.
// Optional macro K_FIFO_CTRL_FLUSH_EN adds a synchronous flush port.
module k_fifo_ctrl
  import k_fifo_pkg::*;
#(
  parameter int ADDR_SIZE = 1,
  parameter int AFULL_LVL = k_fifo_depth(ADDR_SIZE) - 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
`ifdef K_FIFO_CTRL_FLUSH_EN
  input  logic                 flush,
`endif
  output logic                 wen,
  output logic [ADDR_SIZE-1:0] waddr,
  output logic [ADDR_SIZE-1:0] raddr,
  output logic [ADDR_SIZE:0]   count,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full
);

  localparam int PW = k_fifo_ptr_w(ADDR_SIZE);
  localparam logic [PW-1:0] DEPTH_C =
    PW'(k_fifo_depth(ADDR_SIZE));
  localparam logic [PW-1:0] AFULL_C = PW'(AFULL_LVL);

  if (!k_fifo_afull_ok(AFULL_LVL, ADDR_SIZE)) begin : g_bad_afull
    $error("k_fifo_ctrl: AFULL_LVL outside 1..DEPTH");
  end

  logic          flush_i;
  logic          push;
  logic          pop;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] count_q;
  logic [PW-1:0] count_nx;
  logic          full_q;
  logic          empty_q;
  logic          afull_q;

`ifdef K_FIFO_CTRL_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  // no pass-through: a full FIFO refuses push even if popping
  assign in_ready  = !full_q;
  assign out_valid = !empty_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign wen       = push;

  assign waddr = wr_ptr[ADDR_SIZE-1:0];
  assign raddr = rd_ptr[ADDR_SIZE-1:0];

  k_fifo_ptr #(
    .W(PW)
  ) u_wr_ptr (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (push),
    .clr  (flush_i),
    .ptr  (wr_ptr)
  );

  k_fifo_ptr #(
    .W(PW)
  ) u_rd_ptr (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (pop),
    .clr  (flush_i),
    .ptr  (rd_ptr)
  );

  // next occupancy; flush drops everything including this cycle's ops
  always_comb begin
    count_nx = count_q;
    unique case (1'b1)
      flush_i:      count_nx = '0;
      push && !pop: count_nx = count_q + 1'b1;
      pop && !push: count_nx = count_q - 1'b1;
      default:      count_nx = count_q;
    endcase
  end

  // occupancy and status flags registered from next-state count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      afull_q <= 1'b0;
    end else begin
      count_q <= count_nx;
      full_q  <= (count_nx == DEPTH_C);
      empty_q <= (count_nx == '0);
      afull_q <= (count_nx >= AFULL_C);
    end
  end

  assign count       = count_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign almost_full = afull_q;

endmodule

// File: tb/tb_k_fifo_ctrl.sv
// Directed + short random bench for k_fifo_ctrl with a local
// storage array and a queue scoreboard of pushed words.
module tb_k_fifo_ctrl;

  localparam int AS    = 1;
  localparam int DEPTH = 1 << AS;
  localparam int AFL   = DEPTH - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          flush = 1'b0;
  logic          in_ready, out_valid, wen;
  logic [AS-1:0] waddr, raddr;
  logic [AS:0]   count;
  logic          full, empty, almost_full;
  logic [7:0]    din = 8'h00;
  logic [7:0]    mem [DEPTH];
  logic [7:0]    q;

  int tests = 0;
  int fails = 0;

  int        m_count = 0;
  logic [AS:0] m_wr = '0;
  logic [AS:0] m_rd = '0;
  logic [7:0]  sb[$];

  always #5 clk = ~clk;

  k_fifo_ctrl #(
    .ADDR_SIZE(AS),
    .AFULL_LVL(AFL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
`ifdef K_FIFO_CTRL_FLUSH_EN
    .flush      (flush),
`endif
    .wen        (wen),
    .waddr      (waddr),
    .raddr      (raddr),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .almost_full(almost_full)
  );

  always @(posedge clk) if (wen) mem[waddr] <= din;
  assign q = mem[raddr];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_count = 0;
    m_wr = '0;
    m_rd = '0;
    sb.delete();
  endtask

  task automatic chk_status(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(m_count));
    chk({tag, ".full"}, 32'(full), 32'(m_count == DEPTH));
    chk({tag, ".empty"}, 32'(empty), 32'(m_count == 0));
    chk({tag, ".afull"}, 32'(almost_full), 32'(m_count >= AFL));
  endtask

  // one clock: drive, check at negedge, advance model at the edge
  task automatic cycle(input string tag, input logic iv,
                       input logic [7:0] d, input logic ordy,
                       input logic fl);
    logic e_push, e_pop;
    in_valid = iv; din = d; out_ready = ordy; flush = fl;
    @(negedge clk);
    e_push = iv && (m_count != DEPTH);
    e_pop  = ordy && (m_count != 0);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(m_count != DEPTH));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_count != 0));
    chk({tag, ".wen"}, 32'(wen), 32'(e_push));
    chk({tag, ".waddr"}, 32'(waddr), 32'(m_wr[AS-1:0]));
    chk({tag, ".raddr"}, 32'(raddr), 32'(m_rd[AS-1:0]));
    chk_status(tag);
    if (e_pop) begin
      if (sb.size() == 0) chk({tag, ".sb_empty"}, 32'd1, 32'd0);
      else chk({tag, ".q"}, 32'(q), 32'(sb.pop_front()));
    end
    if (e_push) sb.push_back(d);
    if (fl) begin
      model_reset();
    end else begin
      m_count = m_count + int'(e_push) - int'(e_pop);
      m_wr = m_wr + AS'(0) + (e_push ? 1 : 0);
      m_rd = m_rd + (e_pop ? 1 : 0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset held, then idle
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.empty", 32'(empty), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    cycle("idle", 1'b0, 8'h00, 1'b0, 1'b0);

    // fill to full, third push refused
    cycle("fill0", 1'b1, 8'hA5, 1'b0, 1'b0);
    cycle("fill1", 1'b1, 8'h3C, 1'b0, 1'b0);
    cycle("refuse", 1'b1, 8'hFF, 1'b0, 1'b0);

    // drain in order
    cycle("drain0", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("drain1", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("drained", 1'b0, 8'h00, 1'b1, 1'b0);

    // streaming at count=1: pointers wrap repeatedly
    cycle("s_pre", 1'b1, 8'h10, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      cycle("stream", 1'b1, 8'(8'h20 + i), 1'b1, 1'b0);

    // full with push+pop: pop only, then push lands
    cycle("f_pre", 1'b1, 8'h77, 1'b0, 1'b0);
    cycle("f_both", 1'b1, 8'h88, 1'b1, 1'b0);
    cycle("f_retry", 1'b1, 8'h88, 1'b0, 1'b0);
    cycle("f_post", 1'b0, 8'h00, 1'b0, 1'b0);

    // async reset mid-operation discards contents
    #2 rst_n = 1'b0;
    #1;
    chk("arst.count", 32'(count), 32'd0);
    chk("arst.empty", 32'(empty), 32'd1);
    chk("arst.full", 32'(full), 32'd0);
    chk("arst.raddr", 32'(raddr), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    cycle("post_rst", 1'b0, 8'h00, 1'b1, 1'b0);

`ifdef K_FIFO_CTRL_FLUSH_EN
    cycle("fl_a", 1'b1, 8'h51, 1'b0, 1'b0);
    cycle("fl_b", 1'b1, 8'h52, 1'b0, 1'b0);
    cycle("fl_go", 1'b1, 8'h53, 1'b1, 1'b1);
    cycle("fl_after", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("fl_push", 1'b1, 8'h54, 1'b0, 1'b0);
    cycle("fl_pop", 1'b0, 8'h00, 1'b1, 1'b0);
`endif

    // random traffic against the scoreboard
    for (int i = 0; i < 60; i++)
      cycle("rnd", 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), 1'b0);

    // final drain
    for (int i = 0; i < DEPTH + 1; i++)
      cycle("fin", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("fin.sb", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
